// File: rtl/thread_status_tracker_pkg.sv
// Shared thread types for the scheduler-side status logic.
// Thread ids, per-thread state encoding and exception causes.
package common;

    localparam int n_threads = 8;
    localparam int THREAD_W  = $clog2(n_threads);

    typedef logic [THREAD_W-1:0] threadid_t;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        WAIT_MEM = 2'd1,
        EXC_PEND = 2'd2
    } thread_state_t;

    typedef enum logic {
        CAUSE_PIPE    = 1'b0,
        CAUSE_TIMEOUT = 1'b1
    } exc_cause_t;

endpackage

// File: rtl/thread_status_tracker_fsm.sv
// One hardware thread: run / wait-on-memory / exception-pending,
// with its memory wait counter and the cause of a pending exception.
module thread_status_fsm
    import common::*;
#(
    parameter int TIMEOUT   = 255,
    parameter int TIMEOUT_W = 8
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       miss_i,
    input  logic       fill_i,
    input  logic       exc_req_i,
    input  logic       grant_i,
    output logic       stalled_o,
    output logic       pend_o,
    output exc_cause_t cause_o
);

    localparam logic [TIMEOUT_W-1:0] TMO_LAST = TIMEOUT_W'(TIMEOUT - 1);

    thread_state_t        state_q, state_d;
    logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
    exc_cause_t           cause_q, cause_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= RUN;
            cnt_q   <= '0;
            cause_q <= CAUSE_PIPE;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cause_q <= cause_d;
        end
    end

    // Pipeline request outranks fill, miss and timeout in the same cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cause_d = cause_q;
        unique case (state_q)
            RUN: begin
                if (exc_req_i) begin
                    state_d = EXC_PEND;
                    cause_d = CAUSE_PIPE;
                end else if (miss_i) begin
                    state_d = WAIT_MEM;
                    cnt_d   = '0;
                end
            end
            WAIT_MEM: begin
                if (exc_req_i) begin
                    state_d = EXC_PEND;
                    cause_d = CAUSE_PIPE;
                end else if (fill_i && miss_i) begin
                    cnt_d = '0;
                end else if (fill_i) begin
                    state_d = RUN;
                end else if (cnt_q == TMO_LAST) begin
                    state_d = EXC_PEND;
                    cause_d = CAUSE_TIMEOUT;
                end else begin
                    cnt_d = cnt_q + TIMEOUT_W'(1);
                end
            end
            EXC_PEND: begin
                if (grant_i) begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    always_comb begin
        stalled_o = (state_q != RUN);
        pend_o    = (state_q == EXC_PEND);
        cause_o   = cause_q;
    end

endmodule

// File: rtl/thread_status_tracker.sv
// Per-thread stall tracking plus a round-robin exception redirect
// arbiter feeding the thread scheduler.
module thread_status_tracker
    import common::*;
#(
    parameter int N_THREADS = n_threads,
    parameter int TIMEOUT   = 255,
    parameter int TIMEOUT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 miss_en,
    input  threadid_t            miss_thread,
    input  logic                 fill_en,
    input  threadid_t            fill_thread,
    input  logic [N_THREADS-1:0] exc_req,
    output logic [N_THREADS-1:0] stalled,
    output logic                 all_stalled,
    output logic                 exc_en,
    output threadid_t            exc_thread,
    output logic                 exc_cause
);

    logic [N_THREADS-1:0] pend;
    logic [N_THREADS-1:0] grant;
    exc_cause_t           cause [N_THREADS];

    threadid_t rr_q, rr_d;
    logic      exc_en_q, exc_en_d;
    threadid_t exc_thread_q, exc_thread_d;
    logic      exc_cause_q, exc_cause_d;

    logic      gnt_vld;
    threadid_t gnt_id;
    int        idx;

    for (genvar i = 0; i < N_THREADS; i++) begin : g_thr
        thread_status_fsm #(
            .TIMEOUT   (TIMEOUT),
            .TIMEOUT_W (TIMEOUT_W)
        ) u_fsm (
            .clk_i     (clk),
            .rst_ni    (rst),
            .miss_i    (miss_en && (miss_thread == threadid_t'(i))),
            .fill_i    (fill_en && (fill_thread == threadid_t'(i))),
            .exc_req_i (exc_req[i]),
            .grant_i   (grant[i]),
            .stalled_o (stalled[i]),
            .pend_o    (pend[i]),
            .cause_o   (cause[i])
        );
    end

    // First pending thread at or after rr_q, wrapping around.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_id  = '0;
        grant   = '0;
        idx     = 0;
        for (int k = 0; k < N_THREADS; k++) begin
            idx = int'(rr_q) + k;
            if (idx >= N_THREADS) begin
                idx = idx - N_THREADS;
            end
            if (!gnt_vld && pend[idx]) begin
                gnt_vld = 1'b1;
                gnt_id  = threadid_t'(idx);
            end
        end
        if (gnt_vld) begin
            grant[gnt_id] = 1'b1;
        end
    end

    always_comb begin
        rr_d         = rr_q;
        exc_en_d     = gnt_vld;
        exc_thread_d = exc_thread_q;
        exc_cause_d  = exc_cause_q;
        if (gnt_vld) begin
            exc_thread_d = gnt_id;
            exc_cause_d  = logic'(cause[gnt_id]);
            if (gnt_id == threadid_t'(N_THREADS - 1)) begin
                rr_d = '0;
            end else begin
                rr_d = gnt_id + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_q         <= '0;
            exc_en_q     <= 1'b0;
            exc_thread_q <= '0;
            exc_cause_q  <= 1'b0;
        end else begin
            rr_q         <= rr_d;
            exc_en_q     <= exc_en_d;
            exc_thread_q <= exc_thread_d;
            exc_cause_q  <= exc_cause_d;
        end
    end

    assign all_stalled = &stalled;
    assign exc_en      = exc_en_q;
    assign exc_thread  = exc_thread_q;
    assign exc_cause   = exc_cause_q;

endmodule

// File: tb/tb_thread_status_tracker.sv
// Directed bench: expected redirects go into a scoreboard queue that a
// negedge monitor drains; stall vector is checked at fixed points.
module tb_thread_status_tracker;
    import common::*;

    localparam int N  = 8;
    localparam int TO = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic            miss_en;
    threadid_t       miss_thread;
    logic            fill_en;
    threadid_t       fill_thread;
    logic [N-1:0]    exc_req;
    logic [N-1:0]    stalled;
    logic            all_stalled;
    logic            exc_en;
    threadid_t       exc_thread;
    logic            exc_cause;

    int cyc = 0;
    int checks = 0;
    int failures = 0;
    int t, a, b, c;

    typedef struct {
        int tid;
        int cause;
        int cyc;
    } exp_t;

    exp_t sb[$];

    thread_status_tracker #(
        .N_THREADS (N),
        .TIMEOUT   (TO),
        .TIMEOUT_W (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .miss_en     (miss_en),
        .miss_thread (miss_thread),
        .fill_en     (fill_en),
        .fill_thread (fill_thread),
        .exc_req     (exc_req),
        .stalled     (stalled),
        .all_stalled (all_stalled),
        .exc_en      (exc_en),
        .exc_thread  (exc_thread),
        .exc_cause   (exc_cause)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    task automatic expect_exc(input int tid, input int cause, input int at);
        exp_t e;
        e.tid   = tid;
        e.cause = cause;
        e.cyc   = at;
        sb.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        miss_en = 1'b0;
        fill_en = 1'b0;
        exc_req = '0;
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst && exc_en) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_exc: thread=%0d cause=%0d cycle=%0d, expected none",
                             exc_thread, exc_cause, cyc);
                end else begin
                    e = sb.pop_front();
                    if (int'(exc_thread) != e.tid || int'(exc_cause) != e.cause
                        || cyc != e.cyc) begin
                        failures++;
                        $display("FAIL exc_grant: got thread=%0d cause=%0d cycle=%0d expected thread=%0d cause=%0d cycle=%0d",
                                 exc_thread, exc_cause, cyc, e.tid, e.cause, e.cyc);
                    end
                end
            end
        end
    endtask

    initial begin
        rst         = 1'b0;
        miss_thread = '0;
        fill_thread = '0;
        idle();
        fork
            monitor();
        join_none

        repeat (2) step();
        chk("rst_stalled", int'(stalled), 0);
        chk("rst_all_stalled", int'(all_stalled), 0);
        chk("rst_exc_en", int'(exc_en), 0);
        chk("rst_exc_thread", int'(exc_thread), 0);
        chk("rst_exc_cause", int'(exc_cause), 0);
        rst = 1'b1;
        step();

        // miss thread 3, fill four edges later
        miss_en = 1'b1; miss_thread = 3; step(); idle();
        chk("miss3_stalled", int'(stalled), 8'h08);
        repeat (3) begin
            step();
            chk("wait3_stalled", int'(stalled), 8'h08);
        end
        fill_en = 1'b1; fill_thread = 3; step(); idle();
        chk("fill3_stalled", int'(stalled), 0);

        // grant thread 0 first so rr = 1, then three requests at once
        exc_req = 8'h01; step(); idle();
        expect_exc(0, 0, cyc + 1);
        step();
        exc_req = 8'h85; step(); idle();
        expect_exc(2, 0, cyc + 1);
        expect_exc(7, 0, cyc + 2);
        expect_exc(0, 0, cyc + 3);
        chk("rr_pend_stalled", int'(stalled), 8'h85);
        step();
        chk("rr_after_g2", int'(stalled), 8'h81);
        step();
        chk("rr_after_g7", int'(stalled), 8'h01);
        step();
        chk("rr_after_g0", int'(stalled), 0);

        // timeout on thread 6, late fill ignored
        miss_en = 1'b1; miss_thread = 6; step(); idle();
        t = cyc;
        expect_exc(6, 1, t + TO + 1);
        repeat (TO - 1) step();
        chk("tmo_wait_stalled", int'(stalled), 8'h40);
        step();
        chk("tmo_pend_stalled", int'(stalled), 8'h40);
        step();
        chk("tmo_granted_stalled", int'(stalled), 0);
        step();
        fill_en = 1'b1; fill_thread = 6; step(); idle();
        chk("tmo_late_fill", int'(stalled), 0);
        repeat (3) step();

        // fill+miss on thread 1 at counter 3 restarts the wait
        miss_en = 1'b1; miss_thread = 1; step(); idle();
        a = cyc;
        repeat (3) step();
        miss_en = 1'b1; fill_en = 1'b1;
        miss_thread = 1; fill_thread = 1;
        step(); idle();
        chk("fm_stalled", int'(stalled), 8'h02);
        expect_exc(1, 1, a + 4 + TO + 1);
        repeat (TO) step();
        chk("fm_pend_stalled", int'(stalled), 8'h02);
        step();
        chk("fm_granted_stalled", int'(stalled), 0);

        // exc_req beats fill on thread 4
        miss_en = 1'b1; miss_thread = 4; step(); idle();
        exc_req = 8'h10; fill_en = 1'b1; fill_thread = 4; step(); idle();
        b = cyc;
        expect_exc(4, 0, b + 1);
        chk("excfill_stalled", int'(stalled), 8'h10);
        step();
        chk("excfill_granted", int'(stalled), 0);

        // all eight threads waiting, then all time out in order
        c = 0;
        for (int k = 0; k < N; k++) begin
            miss_en = 1'b1; miss_thread = threadid_t'(k); step();
            if (k == 0) c = cyc;
            if (k == N - 2) chk("all_stalled_7of8", int'(all_stalled), 0);
        end
        idle();
        chk("all_stalled_8of8", int'(all_stalled), 1);
        chk("all_stalled_vec", int'(stalled), 8'hff);
        for (int k = 0; k < N; k++) begin
            expect_exc(k, 1, c + k + TO + 1);
        end
        repeat (TO + 3) step();
        chk("all_drained_stalled", int'(stalled), 0);

        // async reset with waits and a pending exception outstanding
        miss_en = 1'b1; miss_thread = 2; step();
        miss_thread = 5; step(); idle();
        exc_req = 8'h08; step(); idle();
        chk("prerst_stalled", int'(stalled), 8'h2c);
        #2;
        rst = 1'b0;
        #1;
        chk("midrst_stalled", int'(stalled), 0);
        chk("midrst_exc_en", int'(exc_en), 0);
        chk("midrst_exc_thread", int'(exc_thread), 0);
        chk("midrst_exc_cause", int'(exc_cause), 0);
        chk("midrst_all_stalled", int'(all_stalled), 0);
        step();
        rst = 1'b1;
        repeat (TO + 3) step();
        chk("postrst_stalled", int'(stalled), 0);

        chk("sb_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
